// File: rtl/sram_bist_logger.sv
// Captures the first DEPTH BIST read mismatches (address, expected, actual) in arrival
// order, keeps a saturating error count and flags overflow beyond the record capacity.
module sram_bist_logger #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     log_start,
    input  logic                     cmp_valid,
    input  logic [ADDR_W-1:0]        cmp_address,
    input  logic [DATA_W-1:0]        cmp_expected,
    input  logic [DATA_W-1:0]        cmp_actual,
    input  logic                     bist_finish,
    input  logic [$clog2(DEPTH)-1:0] log_index,
    output logic [ADDR_W-1:0]        log_address,
    output logic [DATA_W-1:0]        log_expected,
    output logic [DATA_W-1:0]        log_actual,
    output logic                     log_entry_valid,
    output logic [CNT_W-1:0]         error_count,
    output logic                     log_overflow,
    output logic                     any_mismatch,
    output logic [1:0]               log_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               start_prev;
    logic               start_edge;
    logic               capture;
    logic               store;
    logic [IDX_W:0]     rec_count;
    logic [IDX_W-1:0]   wr_idx;
    logic [DEPTH-1:0]   rec_valid;
    logic [ADDR_W-1:0]  rec_address  [DEPTH];
    logic [DATA_W-1:0]  rec_expected [DEPTH];
    logic [DATA_W-1:0]  rec_actual   [DEPTH];

    assign start_edge = log_start & ~start_prev;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start edge re-arms from any state and wins over bist_finish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = ARMED;
            ARMED:   if (start_edge) state_next = ARMED;
                     else if (bist_finish) state_next = DONE;
            DONE:    if (start_edge) state_next = ARMED;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        log_state = state;
        capture   = (state == ARMED) && cmp_valid && (cmp_expected != cmp_actual) && !start_edge;
        store     = capture && (rec_count < FULL);
    end

    assign wr_idx = rec_count[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            start_prev   <= 1'b0;
            error_count  <= '0;
            rec_count    <= '0;
            rec_valid    <= '0;
            log_overflow <= 1'b0;
        end else begin
            start_prev <= log_start;
            if (start_edge) begin
                error_count  <= '0;
                rec_count    <= '0;
                rec_valid    <= '0;
                log_overflow <= 1'b0;
            end else if (capture) begin
                if (error_count != '1) error_count <= error_count + CNT_W'(1);
                if (store) begin
                    rec_valid[wr_idx] <= 1'b1;
                    rec_count         <= rec_count + (IDX_W + 1)'(1);
                end else begin
                    log_overflow <= 1'b1;
                end
            end
        end
    end

    // Record payloads need no reset; readout is gated by the valid bits.
    always_ff @(posedge clock) begin
        if (resetn && store) begin
            rec_address[wr_idx]  <= cmp_address;
            rec_expected[wr_idx] <= cmp_expected;
            rec_actual[wr_idx]   <= cmp_actual;
        end
    end

    always_comb begin
        log_entry_valid = rec_valid[log_index];
        log_address     = log_entry_valid ? rec_address[log_index]  : '0;
        log_expected    = log_entry_valid ? rec_expected[log_index] : '0;
        log_actual      = log_entry_valid ? rec_actual[log_index]   : '0;
    end

    assign any_mismatch = |error_count;

endmodule

// File: tb/tb_sram_bist_logger.sv
// Bench for sram_bist_logger: directed scenarios plus random traffic, checked every
// cycle against a queue-based model; a second instance uses a 4-bit error counter.
module tb_sram_bist_logger;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] e;
    logic [15:0] x;
  } rec_t;

  logic        clock = 1'b0;
  logic        resetn, log_start, cmp_valid, bist_finish;
  logic [17:0] cmp_address;
  logic [15:0] cmp_expected, cmp_actual;
  logic [1:0]  log_index = 2'd0;

  logic [17:0] la16, la4;
  logic [15:0] le16, lx16, le4, lx4, cnt16;
  logic [3:0]  cnt4;
  logic        lv16, lv4, ovf16, ovf4, any16, any4;
  logic [1:0]  st16, st4;

  int checks = 0;
  int failures = 0;

  // Behavioural model
  rec_t recs[$];
  int   m_total = 0;
  int   m_state = 0;
  bit   m_ovf = 0;
  bit   m_prev = 0;
  bit   started = 0;

  sram_bist_logger #(.DEPTH(DEPTH), .ADDR_W(18), .DATA_W(16), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .log_start(log_start), .cmp_valid(cmp_valid),
    .cmp_address(cmp_address), .cmp_expected(cmp_expected), .cmp_actual(cmp_actual),
    .bist_finish(bist_finish), .log_index(log_index), .log_address(la16),
    .log_expected(le16), .log_actual(lx16), .log_entry_valid(lv16), .error_count(cnt16),
    .log_overflow(ovf16), .any_mismatch(any16), .log_state(st16)
  );

  sram_bist_logger #(.DEPTH(DEPTH), .ADDR_W(18), .DATA_W(16), .CNT_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .log_start(log_start), .cmp_valid(cmp_valid),
    .cmp_address(cmp_address), .cmp_expected(cmp_expected), .cmp_actual(cmp_actual),
    .bist_finish(bist_finish), .log_index(log_index), .log_address(la4),
    .log_expected(le4), .log_actual(lx4), .log_entry_valid(lv4), .error_count(cnt4),
    .log_overflow(ovf4), .any_mismatch(any4), .log_state(st4)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: consumes the inputs seen at each rising edge
  always @(posedge clock) begin
    bit st_edge;
    if (!resetn) begin
      recs.delete();
      m_total = 0; m_state = 0; m_ovf = 0; m_prev = 0;
      started = 1;
    end else begin
      st_edge = log_start && !m_prev;
      m_prev = log_start;
      if (st_edge) begin
        recs.delete();
        m_total = 0; m_ovf = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (cmp_valid && cmp_expected != cmp_actual) begin
          m_total++;
          if (recs.size() < DEPTH) recs.push_back('{cmp_address, cmp_expected, cmp_actual});
          else m_ovf = 1;
        end
        if (bist_finish) m_state = 2;
      end
    end
  end

  // Compare process: every cycle, all scalar outputs and every record slot
  always begin
    @(negedge clock);
    if (started) begin
      chk("state16", st16, m_state);
      chk("state4", st4, m_state);
      chk("count16", cnt16, (m_total > 65535) ? 65535 : m_total);
      chk("count4", cnt4, (m_total > 15) ? 15 : m_total);
      chk("ovf16", ovf16, m_ovf);
      chk("ovf4", ovf4, m_ovf);
      chk("any16", any16, m_total != 0);
      chk("any4", any4, m_total != 0);
      for (int i = 0; i < DEPTH; i++) begin
        rec_t r;
        bit   v;
        log_index = 2'(i);
        #1;
        v = (i < recs.size());
        r = v ? recs[i] : '0;
        chk("rec_valid", lv16, v);
        chk("rec_addr", la16, r.a);
        chk("rec_exp", le16, r.e);
        chk("rec_act", lx16, r.x);
        chk("rec4_valid", lv4, v);
        chk("rec4_addr", la4, r.a);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input logic [17:0] a, input logic [15:0] e, input logic [15:0] x,
                     input logic fin = 1'b0);
    cmp_valid = 1'b1; cmp_address = a; cmp_expected = e; cmp_actual = x; bist_finish = fin;
    step();
    cmp_valid = 1'b0; bist_finish = 1'b0;
  endtask

  task automatic start_edge();
    log_start = 1'b0;
    step();
    log_start = 1'b1;
    step();
    log_start = 1'b0;
  endtask

  task automatic finish_pulse();
    bist_finish = 1'b1;
    step();
    bist_finish = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    resetn = 1'b0; log_start = 1'b0; cmp_valid = 1'b0; bist_finish = 1'b0;
    cmp_address = '0; cmp_expected = '0; cmp_actual = '0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    chk("pin_reset_state", m_state, 0);

    // Clean run: matching compares only
    start_edge();
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      cmp(18'($urandom), d, d);
    end
    finish_pulse();
    chk("pin_clean_state", m_state, 2);
    chk("pin_clean_count", m_total, 0);

    // Two mismatches at boundary addresses
    start_edge();
    cmp(18'h00010, 16'hAAAA, 16'h2AAA);
    cmp(18'h3FFFF, 16'h5555, 16'h5554);
    step();
    chk("pin_two_count", m_total, 2);
    chk("pin_two_rec0", recs[0], {18'h00010, 16'hAAAA, 16'h2AAA});
    chk("pin_two_rec1", recs[1], {18'h3FFFF, 16'h5555, 16'h5554});
    chk("pin_two_size", recs.size(), 2);

    // Six mismatches overflow the four records
    start_edge();
    for (int i = 0; i < 6; i++) cmp(18'(i * 3 + 1), 16'h1234, 16'(16'h1234 ^ (1 << i)));
    chk("pin_six_count", m_total, 6);
    chk("pin_six_ovf", m_ovf, 1);
    chk("pin_six_last", recs[3], {18'd10, 16'h1234, 16'h123C});

    // Mismatch coincident with finish, then ignored traffic in DONE
    start_edge();
    cmp(18'h00123, 16'hFFFF, 16'h0000, 1'b1);
    chk("pin_fin_state", m_state, 2);
    for (int i = 0; i < 5; i++) cmp(18'($urandom), 16'h0F0F, 16'hF0F0);
    chk("pin_fin_count", m_total, 1);

    // Re-arm from DONE, then start edge together with finish while ARMED
    start_edge();
    for (int i = 0; i < 3; i++) cmp(18'(i), 16'h0001, 16'h0002);
    finish_pulse();
    start_edge();
    chk("pin_rearm_state", m_state, 1);
    chk("pin_rearm_count", m_total, 0);
    cmp(18'h2, 16'h1, 16'h3);
    cmp(18'h3, 16'h1, 16'h5);
    log_start = 1'b1; bist_finish = 1'b1;
    step();
    log_start = 1'b0; bist_finish = 1'b0;
    chk("pin_restart_state", m_state, 1);
    chk("pin_restart_count", m_total, 0);

    // Saturation of the 4-bit counter, then reset mid-run with log_start held
    start_edge();
    for (int i = 0; i < 17; i++) cmp(18'(i), 16'hC3C3, 16'(~i));
    chk("pin_sat_total", m_total, 17);
    log_start = 1'b1; resetn = 1'b0;
    step();
    chk("pin_rst_state", m_state, 0);
    resetn = 1'b1;
    step();
    chk("pin_rst_edge_state", m_state, 1);
    log_start = 1'b0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      resetn      = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 24) == 0) log_start = ~log_start;
      cmp_valid    = $urandom_range(0, 1);
      cmp_address  = 18'($urandom);
      cmp_expected = 16'($urandom);
      cmp_actual   = ($urandom_range(0, 1) != 0) ? cmp_expected
                     : 16'(cmp_expected ^ (16'h1 << $urandom_range(0, 15)));
      bist_finish  = ($urandom_range(0, 39) == 0);
      step();
    end
    resetn = 1'b1; cmp_valid = 1'b0; bist_finish = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
